// File: rtl/arbitro_raiz_pkg.sv
// Shared definitions for the square-root core arbiter: FSM encodings and result constants.
// Timeout support is enabled by defining ARBITRO_RAIZ_TIMEOUT_EN.
package arbitro_raiz_pkg;

    typedef enum logic [1:0] {
        ST_LIBRE     = 2'd0,
        ST_ARRANQUE  = 2'd1,
        ST_ENTREGA   = 2'd2,
        ST_DESCARGA  = 2'd3
    } estado_t;

    localparam int          ANCHO_RAIZ  = 16;
    localparam logic [15:0] RES_TIMEOUT = 16'hFFFF;

    // Round-robin successor of a requester index.
    function automatic int siguiente_rr(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/arbitro_raiz_selector_rr.sv
// Combinational round-robin picker: first active request at or after ptr, wrapping around.
// Used by arbitro_raiz (see ARBITRO_RAIZ_TIMEOUT_EN there for the optional timeout).
module selector_rr
    import arbitro_raiz_pkg::*;
#(
    parameter int NUM_SOLIC = 4,
    parameter int IW        = $clog2(NUM_SOLIC)
) (
    input  logic [NUM_SOLIC-1:0] solicitud,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_SOLIC-1:0] ganador,
    output logic [IW-1:0]        indice,
    output logic                 alguno
);

    always_comb begin : busqueda
        int j;
        j       = 0;
        ganador = '0;
        indice  = '0;
        alguno  = 1'b0;
        for (int k = 0; k < NUM_SOLIC; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_SOLIC) j = j - NUM_SOLIC;
            if (!alguno && solicitud[j]) begin
                ganador[j] = 1'b1;
                indice     = IW'(j);
                alguno     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_raiz.sv
// Round-robin arbiter sharing one raiz_cuadrada core among NUM_SOLIC requesters.
// Define ARBITRO_RAIZ_TIMEOUT_EN to abort a core operation after MAX_CICLOS cycles.
module arbitro_raiz
    import arbitro_raiz_pkg::*;
#(
    parameter int NUM_SOLIC  = 4,
    parameter int ANCHO      = 16,
    parameter int MAX_CICLOS = 64
) (
    input  logic                       reloj,
    input  logic                       reiniciar,
    input  logic [NUM_SOLIC-1:0]       solicitud,
    input  logic [NUM_SOLIC*ANCHO-1:0] valores,
    output logic [NUM_SOLIC-1:0]       concedido,
    output logic [NUM_SOLIC-1:0]       listo,
    output logic [NUM_SOLIC-1:0]       error,
    output logic [ANCHO-1:0]           resultado,
    output logic                       ocupado,
    output logic                       raiz_iniciar,
    output logic [ANCHO-1:0]           raiz_valor,
    input  logic                       raiz_terminado,
    input  logic [ANCHO-1:0]           raiz_resultado
);

    localparam int IW = $clog2(NUM_SOLIC);

    estado_t              estado, estado_sig;
    logic [IW-1:0]        ptr, idx, indice;
    logic [NUM_SOLIC-1:0] ganador;
    logic                 alguno;
    logic                 captura, expira;

    selector_rr #(.NUM_SOLIC(NUM_SOLIC), .IW(IW)) u_selector (
        .solicitud (solicitud),
        .ptr       (ptr),
        .ganador   (ganador),
        .indice    (indice),
        .alguno    (alguno)
    );

    // Only accept done while start is actually asserted, so a stale done is never taken as a result.
    assign captura = (estado == ST_ARRANQUE) && raiz_iniciar && raiz_terminado;

`ifdef ARBITRO_RAIZ_TIMEOUT_EN
    localparam logic [7:0] LIMITE = 8'(MAX_CICLOS - 1);

    logic [7:0]           cnt;
    logic [NUM_SOLIC-1:0] error_q;

    assign expira = (estado == ST_ARRANQUE) && raiz_iniciar && !raiz_terminado && (cnt == LIMITE);
    assign error  = error_q;

    always_ff @(posedge reloj or negedge reiniciar) begin
        if (!reiniciar) begin
            cnt     <= '0;
            error_q <= '0;
        end else begin
            if (estado != ST_ARRANQUE) cnt <= '0;
            else if (raiz_iniciar)     cnt <= cnt + 8'd1;
            error_q <= expira ? concedido : '0;
        end
    end
`else
    assign expira = 1'b0;
    assign error  = '0;
`endif

    always_ff @(posedge reloj or negedge reiniciar) begin
        if (!reiniciar) estado <= ST_LIBRE;
        else            estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            ST_LIBRE:     if (alguno) estado_sig = ST_ARRANQUE;
            ST_ARRANQUE: begin
                if (captura)     estado_sig = ST_ENTREGA;
                else if (expira) estado_sig = ST_DESCARGA;
            end
            ST_ENTREGA:   estado_sig = ST_DESCARGA;
            ST_DESCARGA:  if (!raiz_terminado) estado_sig = ST_LIBRE;
            default:      estado_sig = ST_LIBRE;
        endcase
    end

    always_ff @(posedge reloj or negedge reiniciar) begin
        if (!reiniciar) begin
            ptr          <= '0;
            idx          <= '0;
            concedido    <= '0;
            raiz_valor   <= '0;
            resultado    <= '0;
            raiz_iniciar <= 1'b0;
        end else begin
            // Start rises one cycle after the grant and drops on the edge that leaves ARRANQUE.
            raiz_iniciar <= (estado == ST_ARRANQUE) && (estado_sig == ST_ARRANQUE);
            if (estado == ST_LIBRE && alguno) begin
                idx        <= indice;
                concedido  <= ganador;
                raiz_valor <= valores[int'(indice)*ANCHO +: ANCHO];
            end
            if (captura) resultado <= raiz_resultado;
            if (expira)  resultado <= '1;
            if (estado == ST_ENTREGA || expira) begin
                ptr       <= IW'(siguiente_rr(int'(idx), NUM_SOLIC));
                concedido <= '0;
            end
        end
    end

    assign listo   = (estado == ST_ENTREGA) ? concedido : '0;
    assign ocupado = (estado != ST_LIBRE);

endmodule

// File: tb/tb_arbitro_raiz.sv
// Self-checking bench for arbitro_raiz with a behavioural square-root core model and a result scoreboard.
// Build with ARBITRO_RAIZ_TIMEOUT_EN defined to also exercise the timeout path.
module tb_arbitro_raiz;

    localparam int N = 4;
    localparam int W = 16;

    logic           reloj = 1'b0;
    logic           reiniciar = 1'b1;
    logic [N-1:0]   solicitud = '0;
    logic [N*W-1:0] valores = '0;
    logic [N-1:0]   concedido, listo, error;
    logic [W-1:0]   resultado, raiz_valor;
    logic           ocupado, raiz_iniciar;
    logic           raiz_terminado = 1'b0;
    logic [W-1:0]   raiz_resultado = '0;

    arbitro_raiz #(.NUM_SOLIC(N), .ANCHO(W), .MAX_CICLOS(64)) dut (
        .reloj          (reloj),
        .reiniciar      (reiniciar),
        .solicitud      (solicitud),
        .valores        (valores),
        .concedido      (concedido),
        .listo          (listo),
        .error          (error),
        .resultado      (resultado),
        .ocupado        (ocupado),
        .raiz_iniciar   (raiz_iniciar),
        .raiz_valor     (raiz_valor),
        .raiz_terminado (raiz_terminado),
        .raiz_resultado (raiz_resultado)
    );

    always #5 reloj = ~reloj;

    typedef struct packed {
        logic [3:0]  mask;
        logic [63:0] vals;
        logic [3:0]  ops;
        logic [14:0] orden;
        logic [3:0]  lat;
        logic [3:0]  hold;
    } vec_t;

    typedef struct {
        int          idx;
        logic [15:0] res;
        logic [15:0] val;
    } exp_t;

    exp_t cola[$];
    vec_t vecs [5];

    int checks = 0;
    int errors = 0;
    int ops_done, ops_target, run_len, exp_run;
    int core_cnt, hold_left, lat, hold, tmo_cnt, err_ciclos;
    logic nunca;
    logic ini_prev;
    logic [N-1:0] listo_prev, err_seen;
    logic [W-1:0] res_err;

    function automatic logic [15:0] isqrt(input logic [15:0] v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return 16'(r);
    endfunction

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nombre, act, req);
        end
    endtask

    task automatic push_op(input int i);
        exp_t e;
        e.idx = i;
        e.val = valores[i*W +: W];
        e.res = isqrt(e.val);
        cola.push_back(e);
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the core model.
    task automatic ciclo();
        exp_t e;
        @(negedge reloj);
        if (raiz_iniciar && !ini_prev) chk("iniciar_con_terminado", 32'(raiz_terminado), 0);
        if (listo_prev != 0) chk("listo_un_ciclo", 32'(listo), 0);
        if (ocupado && concedido == 0) run_len++;
        else if (run_len != 0) begin
            chk("descarga_ciclos", run_len, exp_run);
            run_len = 0;
        end
        if (listo != 0) begin
            if (cola.size() == 0) chk("listo_inesperado", 32'(listo), 0);
            else begin
                e = cola.pop_front();
                chk("listo_idx", 32'(listo), 32'(1) << e.idx);
                chk("concedido_en_listo", 32'(concedido), 32'(1) << e.idx);
                chk("raiz_valor", 32'(raiz_valor), 32'(e.val));
                chk("resultado", 32'(resultado), 32'(e.res));
`ifndef ARBITRO_RAIZ_TIMEOUT_EN
                chk("error_cero", 32'(error), 0);
`endif
            end
            ops_done++;
            if (ops_done >= ops_target) solicitud = '0;
        end
        if (error != 0) begin
            err_seen   = error;
            err_ciclos = tmo_cnt;
            res_err    = resultado;
            solicitud  = solicitud & ~error;
            nunca      = 1'b0;
        end
        if (raiz_iniciar) tmo_cnt++;
        ini_prev   = raiz_iniciar;
        listo_prev = listo;
        if (raiz_iniciar) begin
            hold_left = hold;
            if (!nunca) begin
                if (core_cnt >= lat - 1) begin
                    raiz_terminado = 1'b1;
                    raiz_resultado = isqrt(raiz_valor);
                end else core_cnt++;
            end
        end else begin
            core_cnt = 0;
            if (raiz_terminado) begin
                if (hold_left == 0) raiz_terminado = 1'b0;
                else hold_left--;
            end
        end
    endtask

    task automatic reset_dut();
        reiniciar = 1'b0;
        #1;
        chk("reset_salidas", 32'({concedido, listo, error, ocupado, raiz_iniciar}), 0);
        chk("reset_datos", {resultado, raiz_valor}, 0);
        raiz_terminado = 1'b0;
        solicitud = '0;
        core_cnt = 0; hold_left = 0; run_len = 0; ops_done = 0; tmo_cnt = 0;
        ini_prev = 1'b0; listo_prev = '0; nunca = 1'b0; err_seen = '0;
        cola.delete();
        @(negedge reloj);
        @(negedge reloj);
        reiniciar = 1'b1;
    endtask

    task automatic esperar_ops(input string nombre);
        int b;
        b = 0;
        while (ops_done < ops_target && b < 600) begin
            ciclo();
            b++;
        end
        if (ops_done < ops_target) chk({nombre, "_sin_listo"}, ops_done, ops_target);
    endtask

    task automatic cola_vacia_e_inactivo();
        repeat (5) ciclo();
        chk("cola_vacia", cola.size(), 0);
        chk("inactivo", 32'({concedido, ocupado}), 0);
    endtask

    task automatic run_vec(input vec_t v);
        reset_dut();
        lat = int'(v.lat);
        hold = int'(v.hold);
        exp_run = (hold > 1) ? hold : 1;
        valores = v.vals;
        ops_target = int'(v.ops);
        for (int k = 0; k < int'(v.ops); k++) push_op(int'(v.orden[k*3 +: 3]));
        solicitud = v.mask;
        ciclo();
        chk("latencia_concedido", 32'(concedido), 32'(1) << v.orden[2:0]);
        chk("iniciar_tras_concesion", 32'(raiz_iniciar), 0);
        ciclo();
        chk("latencia_iniciar", 32'(raiz_iniciar), 1);
        esperar_ops("vector");
        cola_vacia_e_inactivo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        vecs[0] = '{mask: 4'b0001, vals: {16'd0, 16'd0, 16'd0, 16'd144}, ops: 4'd1,
                    orden: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}, lat: 4'd5, hold: 4'd0};
        vecs[1] = '{mask: 4'b1111, vals: {16'd0, 16'd65535, 16'd625, 16'd144}, ops: 4'd5,
                    orden: {3'd0, 3'd3, 3'd2, 3'd1, 3'd0}, lat: 4'd3, hold: 4'd0};
        vecs[2] = '{mask: 4'b1010, vals: {16'd99, 16'd0, 16'd100, 16'd0}, ops: 4'd3,
                    orden: {3'd0, 3'd0, 3'd1, 3'd3, 3'd1}, lat: 4'd2, hold: 4'd2};
        vecs[3] = '{mask: 4'b0100, vals: {16'd0, 16'd4000, 16'd0, 16'd0}, ops: 4'd2,
                    orden: {3'd0, 3'd0, 3'd0, 3'd2, 3'd2}, lat: 4'd1, hold: 4'd3};
        vecs[4] = '{mask: 4'b1001, vals: {16'd2, 16'd0, 16'd0, 16'd1}, ops: 4'd3,
                    orden: {3'd0, 3'd0, 3'd0, 3'd3, 3'd0}, lat: 4'd7, hold: 4'd1};
        #1;
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Requester 2 withdraws its request while the core is working.
        reset_dut();
        lat = 4; hold = 0; exp_run = 1; ops_target = 1;
        valores = {16'd0, 16'd900, 16'd0, 16'd0};
        push_op(2);
        solicitud = 4'b0100;
        b = 0;
        while (!raiz_iniciar && b < 20) begin ciclo(); b++; end
        chk("retiro_iniciar_visto", 32'(raiz_iniciar), 1);
        solicitud = '0;
        esperar_ops("retiro");
        cola_vacia_e_inactivo();

        // Asynchronous reset in ARRANQUE, then the pointer must start from requester 0 again.
        reset_dut();
        lat = 3; hold = 0; exp_run = 1; ops_target = 1;
        valores = {16'd0, 16'd0, 16'd36, 16'd49};
        push_op(0);
        solicitud = 4'b0001;
        esperar_ops("previo_reset");
        repeat (3) ciclo();
        solicitud = 4'b0100;
        b = 0;
        while (!raiz_iniciar && b < 20) begin ciclo(); b++; end
        chk("reset_iniciar_visto", 32'(raiz_iniciar), 1);
        #2;
        reiniciar = 1'b0;
        #1;
        chk("reset_async_iniciar", 32'(raiz_iniciar), 0);
        chk("reset_async_ocupado", 32'({ocupado, concedido}), 0);
        reset_dut();
        lat = 3; hold = 0; exp_run = 1; ops_target = 2;
        valores = {16'd0, 16'd0, 16'd36, 16'd49};
        push_op(0);
        push_op(1);
        solicitud = 4'b0011;
        ciclo();
        chk("reset_ptr_cero", 32'(concedido), 32'b0001);
        esperar_ops("tras_reset");
        cola_vacia_e_inactivo();

`ifdef ARBITRO_RAIZ_TIMEOUT_EN
        // Core never answers requester 0; requester 1 is served next.
        reset_dut();
        lat = 2; hold = 0; exp_run = 1; ops_target = 1; nunca = 1'b1;
        valores = {16'd0, 16'd0, 16'd81, 16'd10};
        push_op(1);
        solicitud = 4'b0011;
        b = 0;
        while (err_seen == 0 && b < 200) begin ciclo(); b++; end
        chk("timeout_error_idx", 32'(err_seen), 32'b0001);
        chk("timeout_ciclos", err_ciclos, 64);
        chk("timeout_resultado", 32'(res_err), 32'hFFFF);
        esperar_ops("tras_timeout");
        cola_vacia_e_inactivo();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
